// File: rtl/sr_latch_driver.sv
// Debounces set/clear requests and drives the sr_latch s/r/en pins through a
// setup/strobe/hold sequence, then checks q feedback against the expected value.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | outputs low, waiting for a debounced set or clear event
// SETUP  | s/r driven from exp, en low
// STROBE | s/r driven from exp, en high
// HOLD   | s/r driven from exp, en low again
// CHECK  | all pins low, done pulse, q_fb compared against exp
module sr_latch_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int HOLD_CYCLES     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic en,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PH_MAX = (SETUP_CYCLES > STROBE_CYCLES) ?
                            ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                            ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [DB_W-1:0] DB_FULL   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [PH_W-1:0] SETUP_LD  = PH_W'(SETUP_CYCLES - 1);
    localparam logic [PH_W-1:0] STROBE_LD = PH_W'(STROBE_CYCLES - 1);
    localparam logic [PH_W-1:0] HOLD_LD   = PH_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        CHECK  = 3'd4
    } state_t;

    logic [DB_W-1:0] set_cnt;
    logic [DB_W-1:0] clr_cnt;
    logic            set_armed;
    logic            clr_armed;
    logic            set_ev;
    logic            clr_ev;

    assign set_ev = set_armed && (set_cnt == DB_FULL);
    assign clr_ev = clr_armed && (clr_cnt == DB_FULL);

    // An event always disarms its channel, whether or not the FSM accepts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_cnt   <= '0;
            set_armed <= 1'b1;
        end else if (!set_req) begin
            set_cnt   <= '0;
            set_armed <= 1'b1;
        end else begin
            if (set_cnt != DB_FULL)
                set_cnt <= set_cnt + 1'b1;
            if (set_ev)
                set_armed <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt   <= '0;
            clr_armed <= 1'b1;
        end else if (!clr_req) begin
            clr_cnt   <= '0;
            clr_armed <= 1'b1;
        end else begin
            if (clr_cnt != DB_FULL)
                clr_cnt <= clr_cnt + 1'b1;
            if (clr_ev)
                clr_armed <= 1'b0;
        end
    end

    state_t          state;
    logic [PH_W-1:0] phase;
    logic            exp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            phase <= '0;
            exp_q <= 1'b0;
            s     <= 1'b0;
            r     <= 1'b0;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Clear has priority when both events land together.
                    if (clr_ev || set_ev) begin
                        exp_q <= !clr_ev;
                        s     <= !clr_ev;
                        r     <= clr_ev;
                        busy  <= 1'b1;
                        phase <= SETUP_LD;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase == '0) begin
                        en    <= 1'b1;
                        phase <= STROBE_LD;
                        state <= STROBE;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                STROBE: begin
                    if (phase == '0) begin
                        en    <= 1'b0;
                        phase <= HOLD_LD;
                        state <= HOLD;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                HOLD: begin
                    if (phase == '0) begin
                        s     <= 1'b0;
                        r     <= 1'b0;
                        done  <= 1'b1;
                        phase <= '0;
                        state <= CHECK;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                CHECK: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (q_fb != exp_q)
                        err <= 1'b1;
                end
                default: begin
                    s     <= 1'b0;
                    r     <= 1'b0;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    phase <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: per-cycle stimulus tables, expected pin values
// derived from the documented sequence timing and queued as a scoreboard.
module tb_sr_latch_driver;

    localparam int D   = 4;
    localparam int SU  = 1;
    localparam int STB = 2;
    localparam int HLD = 1;
    localparam int L   = SU + STB + HLD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic q_fb;
    logic s, r, en, busy, done, err;

    always #5 clk = ~clk;

    sr_latch_driver #(
        .DEBOUNCE_CYCLES(D),
        .SETUP_CYCLES(SU),
        .STROBE_CYCLES(STB),
        .HOLD_CYCLES(HLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .set_req(set_req),
        .clr_req(clr_req),
        .q_fb(q_fb),
        .s(s),
        .r(r),
        .en(en),
        .busy(busy),
        .done(done),
        .err(err)
    );

    // Simple model of the latch being driven; optionally forced to read 0.
    bit   q_tie0 = 1'b0;
    logic q_lat;
    always @(posedge clk or posedge rst) begin
        if (rst)
            q_lat <= 1'b0;
        else if (en) begin
            if (s)
                q_lat <= 1'b1;
            else if (r)
                q_lat <= 1'b0;
        end
    end
    assign q_fb = q_tie0 ? 1'b0 : q_lat;

    typedef struct {
        string       name;
        int          n_cyc;
        logic [63:0] set_pat;
        logic [63:0] clr_pat;
        bit          q_tie0;
        int          a1;
        bit          e1;
        int          a2;
        bit          e2;
        int          err_at;
    } case_t;

    case_t      cases[6];
    logic [5:0] sb_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++)
            m[i] = 1'b1;
        return m;
    endfunction

    function automatic case_t mk(input string nm, input int n, input logic [63:0] sp,
                                 input logic [63:0] cp, input bit qt, input int a1,
                                 input bit e1, input int a2, input bit e2, input int ea);
        case_t c;
        c.name = nm; c.n_cyc = n; c.set_pat = sp; c.clr_pat = cp; c.q_tie0 = qt;
        c.a1 = a1; c.e1 = e1; c.a2 = a2; c.e2 = e2; c.err_at = ea;
        return c;
    endfunction

    // Expected {s,r,en,busy,done,err} just after edge n, for sequences whose
    // pins first change after edge a.
    function automatic logic [5:0] expect_at(input case_t c, input int n);
        logic [5:0] v;
        int a;
        bit e;
        int t;
        v = '0;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? c.a1 : c.a2;
            e = (k == 0) ? c.e1 : c.e2;
            if (a >= 0) begin
                t = n - a;
                if (t >= 0 && t <= L) begin
                    v[2] = 1'b1;
                    if (t < L) begin
                        v[5] = e;
                        v[4] = !e;
                    end
                    if (t >= SU && t < SU + STB)
                        v[3] = 1'b1;
                    if (t == L)
                        v[1] = 1'b1;
                end
            end
        end
        if (c.err_at >= 0 && n >= c.err_at)
            v[0] = 1'b1;
        return v;
    endfunction

    task automatic check(input string nm, input int cyc, input logic [5:0] got,
                         input logic [5:0] want);
        n_checks++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s cycle %0d: got s,r,en,busy,done,err=%b expected %b",
                     nm, cyc, got, want);
    endtask

    task automatic run_case(input case_t c);
        logic [5:0] w;
        rst     = 1'b1;
        q_tie0  = c.q_tie0;
        set_req = c.set_pat[0];
        clr_req = c.clr_pat[0];
        #1;
        check({c.name, "/reset"}, -1, {s, r, en, busy, done, err}, 6'b000000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n <= c.n_cyc; n++) begin
            if (n > 0) begin
                @(negedge clk);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL %s cycle %0d: scoreboard empty, got %b expected an entry",
                             c.name, n - 1, {s, r, en, busy, done, err});
                end else begin
                    w = sb_q.pop_front();
                    check(c.name, n - 1, {s, r, en, busy, done, err}, w);
                end
            end
            if (n < c.n_cyc) begin
                set_req = c.set_pat[n];
                clr_req = c.clr_pat[n];
                sb_q.push_back(expect_at(c, n));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cases[0] = mk("set",        16, rng(0, 5),               '0,          1'b0, 4, 1'b1, -1, 1'b0, -1);
        cases[1] = mk("bounce",     20, rng(0, 2) | rng(4, 15),  '0,          1'b0, 8, 1'b1, -1, 1'b0, -1);
        cases[2] = mk("simul",      34, rng(0, 19) | rng(22, 33), rng(0, 19), 1'b0, 4, 1'b0, 26, 1'b1, -1);
        cases[3] = mk("busy_req",   20, rng(0, 5),               rng(2, 19),  1'b0, 4, 1'b1, -1, 1'b0, -1);
        cases[4] = mk("mismatch",   22, rng(0, 5),               rng(10, 15), 1'b1, 4, 1'b1, 14, 1'b0, 9);
        cases[5] = mk("rst_resume", 12, rng(0, 11),              '0,          1'b0, 4, 1'b1, -1, 1'b0, -1);

        for (int i = 0; i < 5; i++)
            run_case(cases[i]);

        // Start a set sequence (err still set from the mismatch case), then
        // reset asynchronously in the middle of STROBE.
        q_tie0  = 1'b0;
        set_req = 1'b1;
        clr_req = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("mid_strobe_pre", 0, {s, r, en, busy, done, err}, 6'b101101);
        #1 rst = 1'b1;
        #1;
        check("mid_strobe_async", 0, {s, r, en, busy, done, err}, 6'b000000);

        run_case(cases[5]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Upstream control stage for the `sr_latch` block. It debounces two request inputs, `set_req` and `clr_req`, and arbitrates between them. It then drives the latch's `s`, `r` and `en` pins with a fixed setup/strobe/hold sequence that never asserts `s` and `r` together. After each operation it checks the latch's `q` feedback and reports any mismatch.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4, consecutive high samples needed to accept a request (≥1)
- SETUP_CYCLES, 1, cycles `s`/`r` is held before `en` rises (≥1)
- STROBE_CYCLES, 2, cycles `en` is high (≥1)
- HOLD_CYCLES, 1, cycles `s`/`r` is held after `en` falls (≥1)

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- set_req  in  1  set request, level, may bounce
- clr_req  in  1  clear request, level, may bounce
- q_fb  in  1  latch `q` feedback
- s  out  1  latch set
- r  out  1  latch reset
- en  out  1  latch enable
- busy  out  1  high while a sequence is in progress
- done  out  1  one-cycle pulse in the CHECK state
- err  out  1  sticky mismatch flag

## Operation
- **Debounce:** one channel per request, each with a saturating counter and an `armed` bit.
  - A low sample clears the counter and sets `armed`=1.
  - A high sample increments the counter.
  - When the counter reaches DEBOUNCE_CYCLES with `armed`=1, the channel emits a one-cycle event and clears `armed`.
  - A further event needs the input to be sampled low at least once, then high again for the full count.
- **Arbitration:** events are accepted only in IDLE.
  - Events arriving in any other state are discarded, and the channel stays disarmed.
  - If set and clear events occur in the same cycle, clear wins; the set event is discarded.
- **FSM states:** IDLE → SETUP → STROBE → HOLD → CHECK → IDLE.
  - **IDLE:** s=r=en=0. An accepted event latches the expected value `exp` (1 for set, 0 for clear) and moves to SETUP.
  - **SETUP:** `s`=exp and `r`=!exp; en=0. Lasts SETUP_CYCLES.
  - **STROBE:** `s`/`r` as in SETUP; en=1. Lasts STROBE_CYCLES.
  - **HOLD:** `s`/`r` as in SETUP; en=0. Lasts HOLD_CYCLES.
  - **CHECK:** s=r=en=0; done=1. Lasts 1 cycle. If q_fb≠exp, `err` is set at the end of the cycle.
- **Output invariants:**
  - `s` and `r` are never both 1.
  - `en` is 1 only in STROBE.
  - busy = (state ≠ IDLE).
- **Output registers:** all outputs are registered. A single phase counter, sized for the largest of SETUP/STROBE/HOLD_CYCLES, is reloaded on every state change.
- **err:** cleared only by `rst`.

## Timing
- **Reset values:** s=0, r=0, en=0, busy=0, done=0, err=0. Also state=IDLE, counters=0, armed=1, exp=0.
- **Reset mid-sequence:** all outputs drop asynchronously and the sequence is abandoned.
- **Request held through reset:** it fires once, DEBOUNCE_CYCLES after the first sampled edge following reset release.
- **Latency:** with the request first sampled high at edge k, `s` or `r` and `busy` rise after edge k+DEBOUNCE_CYCLES. This assumes the FSM is in IDLE.
- **Sequence length:** `busy` stays high for SETUP+STROBE+HOLD+1 cycles.
- **en position:** `en` rises SETUP_CYCLES after `s`/`r` rise.
- **done:** high exactly one cycle, coincident with CHECK.
- **Back-to-back operation:** the earliest next sequence starts on the cycle after CHECK, provided a new event fires in IDLE.
- **Bounce:** a glitch low inside the debounce window restarts the count from 0.

## Test plan
- **Set:** defaults, set_req high for 6 cycles, q_fb follows `s` during STROBE.
  - Expect `s`=1 for 4 cycles starting 4 cycles after the first high sample, `en`=1 for cycles 2–3 of that window, then `done` for 1 cycle, `err`=0, busy=5 cycles.
- **Bounce:** set_req pattern 1,1,1,0,1,1,1,1.
  - Expect no event after the first three highs, and exactly one sequence starting 4 cycles after the second rising sample.
- **Simultaneous requests:** set_req and clr_req rise together and stay high.
  - Expect `r`=1 and `s`=0 for the whole sequence, and no second sequence until a new low→high transition.
- **Request while busy:** clr_req debounced during STROBE of a set sequence.
  - Expect it discarded, with no second sequence while clr_req stays high.
- **Mismatch:** set sequence with q_fb tied 0.
  - Expect `err`=1 after CHECK, remaining 1 through a following clear sequence, and 0 only after `rst`.
- **Reset mid-STROBE:** assert `rst` during STROBE.
  - Expect `s`, `en` and `busy` to go 0 immediately without waiting for a clock edge.
  - After release with set_req held high, expect one full sequence after 4 cycles.
